// File: rtl/ttl_74161_chain.sv
// Cascaded 4-bit synchronous binary counter built from 74161-style stages.
// Stages are joined RCO->ENT and share one parallel load, so the chain
// behaves as a single W-bit counter while keeping per-device pin semantics.

// One 74161 device: 4-bit counter with sync load, ENP/ENT enables, async clear.
module ttl_74161_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_n,
  input  logic       enp,
  input  logic       ent,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       rco
);

  // Nibble register: clear wins, then load, then count when both enables are high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'h0;
    end else if (!load_n) begin
      q <= d;
    end else if (enp && ent) begin
      q <= q + 4'h1;
    end
  end

  // Ripple carry depends only on ENT and terminal count, never on ENP or load.
  always_comb begin
    rco = ent && (q == 4'hF);
  end

endmodule

// Top-level chain: stage 0 takes the external ENT, every higher stage takes
// the RCO of the stage below it.
module ttl_74161_chain #(
  parameter int STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_n,
  input  logic                  enp,
  input  logic                  ent,
  input  logic [4*STAGES-1:0]   d,
  output logic [4*STAGES-1:0]   q,
  output logic [STAGES-1:0]     rco_stage,
  output logic                  rco
);

  logic [STAGES-1:0] ent_chain;

  // Build each stage's ENT from the carry of the stage below.
  always_comb begin
    ent_chain[0] = ent;
    for (int i = 1; i < STAGES; i++) begin
      ent_chain[i] = rco_stage[i-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    ttl_74161_stage u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_n (load_n),
      .enp    (enp),
      .ent    (ent_chain[g]),
      .d      (d[4*g +: 4]),
      .q      (q[4*g +: 4]),
      .rco    (rco_stage[g])
    );
  end

  // Chain carry out is simply the top stage's carry.
  always_comb begin
    rco = rco_stage[STAGES-1];
  end

endmodule
